// File: rtl/shift_pkg.sv
// Shared constants for the operand-2 shift sequencer: shift types, FSM states
// and the amount clamps that keep the iteration count bounded.
package shift_pkg;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // Beyond these counts the result and carry no longer change.
  localparam logic [5:0] CLAMP_ARITH   = 6'd32;
  localparam logic [5:0] CLAMP_LOGICAL = 6'd33;

  function automatic logic [5:0] clamp_amount(input logic [7:0] amt, input logic [5:0] lim);
    return (amt > {2'b00, lim}) ? lim : amt[5:0];
  endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift step of 0..32 positions, reporting the last bit
// shifted out (or carry_in unchanged when k is zero).
module shift_step
  import shift_pkg::*;
(
  input  logic [31:0] data_in,
  input  logic        carry_in,
  input  logic [1:0]  shift_type,
  input  logic [5:0]  k,
  output logic [31:0] data_out,
  output logic        last_out
);

  logic        [32:0] lsl_ext;
  logic        [32:0] lsr_ext;
  logic signed [32:0] asr_ext;
  logic        [31:0] rot;

  // Carry rides in the extra bit so a zero-length step passes it through.
  always_comb begin
    lsl_ext = {carry_in, data_in} << k;
    lsr_ext = {data_in, carry_in} >> k;
    asr_ext = $signed({data_in, carry_in}) >>> k;
    rot     = (data_in >> k) | (data_in << (6'd32 - k));
  end

  always_comb begin
    data_out = data_in;
    last_out = carry_in;
    case (shift_type)
      SH_LSL: begin
        data_out = lsl_ext[31:0];
        last_out = lsl_ext[32];
      end
      SH_LSR: begin
        data_out = lsr_ext[32:1];
        last_out = lsr_ext[0];
      end
      SH_ASR: begin
        data_out = asr_ext[32:1];
        last_out = asr_ext[0];
      end
      default: begin
        data_out = rot;
        last_out = (k == 6'd0) ? carry_in : rot[31];
      end
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle ARM operand-2 shifter: accepts one request, iterates STEP bits
// per cycle, then holds result/carryOut until the consumer takes them.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [1:0]  shiftType,
  input  logic        immForm,
  input  logic [7:0]  amount,
  input  logic [31:0] operand,
  input  logic        carryIn,
  output logic        resultValid,
  input  logic        resultReady,
  output logic [31:0] result,
  output logic        carryOut,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid holds its payload stable until that edge.

  localparam logic [5:0] STEP_K = 6'(STEP);

  state_t      state_q;
  logic [5:0]  rem_q;
  logic [31:0] data_q;
  logic        carry_q;
  logic [1:0]  type_q;
  logic        rrx_q;
  logic [31:0] result_q;
  logic        carry_out_q;

  logic [5:0]  ld_count;
  logic [31:0] ld_data;
  logic        ld_carry;
  logic        ld_rrx;
  logic [5:0]  k;
  logic [5:0]  k_eff;
  logic [31:0] step_data;
  logic        step_last;

  always_comb begin
    ld_count = 6'd0;
    ld_data  = operand;
    ld_carry = carryIn;
    ld_rrx   = 1'b0;
    if (immForm && amount == 8'd0 && (shiftType == SH_LSR || shiftType == SH_ASR)) begin
      ld_count = 6'd32;
    end else if (immForm && amount == 8'd0 && shiftType == SH_ROR) begin
      // RRX is finished at load; the one SHIFT cycle only keeps the latency.
      ld_count = 6'd1;
      ld_rrx   = 1'b1;
      ld_data  = {carryIn, operand[31:1]};
      ld_carry = operand[0];
    end else if (amount != 8'd0) begin
      case (shiftType)
        SH_LSL, SH_LSR: ld_count = clamp_amount(amount, CLAMP_LOGICAL);
        SH_ASR:         ld_count = clamp_amount(amount, CLAMP_ARITH);
        default: begin
          if (amount[4:0] != 5'd0) ld_count = {1'b0, amount[4:0]};
          else                     ld_carry = operand[31];
        end
      endcase
    end
  end

  always_comb begin
    k     = (rem_q < STEP_K) ? rem_q : STEP_K;
    k_eff = rrx_q ? 6'd0 : k;
  end

  shift_step u_step (
    .data_in    (data_q),
    .carry_in   (carry_q),
    .shift_type (type_q),
    .k          (k_eff),
    .data_out   (step_data),
    .last_out   (step_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rem_q       <= 6'd0;
      data_q      <= 32'd0;
      carry_q     <= 1'b0;
      type_q      <= SH_LSL;
      rrx_q       <= 1'b0;
      result_q    <= 32'd0;
      carry_out_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (reqValid) begin
            type_q  <= shiftType;
            data_q  <= ld_data;
            carry_q <= ld_carry;
            rem_q   <= ld_count;
            rrx_q   <= ld_rrx;
            if (ld_count == 6'd0) begin
              result_q    <= ld_data;
              carry_out_q <= ld_carry;
              state_q     <= ST_DONE;
            end else begin
              state_q <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          data_q  <= step_data;
          carry_q <= step_last;
          rem_q   <= rem_q - k;
          if (rem_q == k) begin
            result_q    <= step_data;
            carry_out_q <= step_last;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (resultReady) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign reqReady    = (state_q == ST_IDLE);
  assign resultValid = (state_q == ST_DONE);
  assign busy        = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign result      = result_q;
  assign carryOut    = carry_out_q;
  assign state_dbg   = state_q;

endmodule
